// File: rtl/pci_initiator.sv
// PCI bus initiator: single-address burst read/write with target stop and
// master-abort (DEVSEL# timeout) handling.
//
// state      | meaning
// IDLE       | bus released, waiting for Req
// ADDR       | address phase, FRAME# asserted, command on C/BE#
// DATA       | data phases, IRDY# asserted, FRAME# drops on the last phase
// TURNAROUND | bus released for one cycle, Done pulses with Status
module pci_initiator #(
  parameter int         MAX_BURST      = 8,
  parameter logic [3:0] CMD_WRITE      = 4'b0010,
  parameter logic [3:0] CMD_READ       = 4'b0011,
  parameter int         DEVSEL_TIMEOUT = 5
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Req,
  input  logic             Req_write,
  input  logic [31:0]      Req_addr,
  input  logic [3:0]       Req_len,
  input  logic [31:0]      Wr_data,
  output logic             Wr_ack,
  output logic [31:0]      Rd_data,
  output logic             Rd_valid,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       Status,
  output logic [3:0]       Xfer_count,
  output logic             Frame,
  output logic             Irdy,
  input  logic             Trdy,
  input  logic             Devsel,
  input  logic             Stop,
  inout  wire logic [31:0] Address,
  output wire logic [3:0]  Cbe
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] ADDR       = 2'd1;
  localparam logic [1:0] DATA       = 2'd2;
  localparam logic [1:0] TURNAROUND = 2'd3;

  localparam int             DW       = (DEVSEL_TIMEOUT < 2) ? 1 : $clog2(DEVSEL_TIMEOUT);
  localparam logic [DW-1:0]  DEV_LOAD = DW'(DEVSEL_TIMEOUT - 1);
  localparam logic [3:0]     MAX_LEN  = 4'(MAX_BURST);

  logic [1:0]    state;
  logic          is_write;
  logic [31:0]   addr_q;
  logic [3:0]    len_q;
  logic [3:0]    len_clamped;
  logic [DW-1:0] dev_timer;
  logic          dev_seen;
  logic [3:0]    xfer_q;
  logic [1:0]    status_q;
  logic [31:0]   rd_data_q;
  logic          rd_valid_q;
  logic          last_phase;
  logic          dev_timeout;
  logic          phase_done;
  logic          ad_oe;
  logic [31:0]   ad_out;
  logic          cbe_oe;
  logic [3:0]    cbe_out;

  always_comb begin
    len_clamped = Req_len;
    if (Req_len == 4'd0)
      len_clamped = 4'd1;
    else if (Req_len > MAX_LEN)
      len_clamped = MAX_LEN;
  end

  // Down-counter reaches zero on the last Devsel-high edge the target is allowed.
  assign last_phase  = (xfer_q == len_q - 4'd1);
  assign dev_timeout = (state == DATA) && Devsel && !dev_seen && (dev_timer == '0);
  assign phase_done  = (state == DATA) && !Trdy && !dev_timeout;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state      <= IDLE;
      is_write   <= 1'b0;
      addr_q     <= '0;
      len_q      <= 4'd1;
      dev_timer  <= '0;
      dev_seen   <= 1'b0;
      xfer_q     <= '0;
      status_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (Req) begin
            is_write <= Req_write;
            addr_q   <= Req_addr;
            len_q    <= len_clamped;
            xfer_q   <= '0;
            status_q <= '0;
            state    <= ADDR;
          end
        end
        ADDR: begin
          dev_timer <= DEV_LOAD;
          dev_seen  <= 1'b0;
          state     <= DATA;
        end
        DATA: begin
          if (phase_done) begin
            xfer_q <= xfer_q + 4'd1;
            if (!is_write) begin
              rd_data_q  <= Address;
              rd_valid_q <= 1'b1;
            end
          end
          if (!Devsel)
            dev_seen <= 1'b1;
          else if (!dev_seen && dev_timer != '0)
            dev_timer <= dev_timer - 1'b1;
          // Stop outranks the master-abort timeout on the same edge.
          if (!Stop) begin
            status_q[1] <= 1'b1;
            state       <= TURNAROUND;
          end else if (dev_timeout) begin
            status_q[0] <= 1'b1;
            state       <= TURNAROUND;
          end else if (phase_done && last_phase) begin
            state <= TURNAROUND;
          end
        end
        TURNAROUND: state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

  assign Busy       = (state != IDLE);
  assign Done       = (state == TURNAROUND);
  assign Status     = status_q;
  assign Xfer_count = xfer_q;
  assign Rd_data    = rd_data_q;
  assign Rd_valid   = rd_valid_q;
  assign Wr_ack     = phase_done && is_write;
  assign Irdy       = (state != DATA);
  assign Frame      = (state == ADDR) ? 1'b0 : (state == DATA) ? last_phase : 1'b1;

  assign ad_oe   = (state == ADDR) || ((state == DATA) && is_write);
  assign ad_out  = (state == ADDR) ? addr_q : Wr_data;
  assign Address = ad_oe ? ad_out : 32'bz;

  assign cbe_oe  = (state == ADDR) || (state == DATA);
  assign cbe_out = (state == DATA) ? 4'b0000 : (is_write ? CMD_WRITE : CMD_READ);
  assign Cbe     = cbe_oe ? cbe_out : 4'bz;

endmodule

// File: doc/pci_initiator.md
PCI_INITIATOR -- requirements
Module: pci_initiator

Interface
REQ-001 SHALL have parameter MAX_BURST, default 8, giving the maximum number of data phases per transaction.
REQ-002 SHALL have parameter CMD_WRITE, default 4'b0010, the command driven on Cbe in a write address phase.
REQ-003 SHALL have parameter CMD_READ, default 4'b0011, the command driven on Cbe in a read address phase.
REQ-004 SHALL have parameter DEVSEL_TIMEOUT, default 5, the number of Devsel-high sampled edges that triggers master abort.
REQ-005 SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port Rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port Req, input, 1 bit: start request, sampled only in IDLE.
REQ-008 SHALL have port Req_write, input, 1 bit: 1 = write, 0 = read; captured with Req.
REQ-009 SHALL have port Req_addr, input, 32 bits: start address; captured with Req.
REQ-010 SHALL have port Req_len, input, 4 bits: number of data phases; captured with Req.
REQ-011 SHALL have port Wr_data, input, 32 bits: head word of the upstream show-ahead write queue.
REQ-012 SHALL have port Wr_ack, output, 1 bit: combinational pop; high in the cycle where a write data phase completes.
REQ-013 SHALL have port Rd_data, output, 32 bits: registered read word.
REQ-014 SHALL have port Rd_valid, output, 1 bit: one-cycle strobe qualifying Rd_data.
REQ-015 SHALL have port Busy, output, 1 bit: high in every state except IDLE.
REQ-016 SHALL have port Done, output, 1 bit: one-cycle pulse in TURNAROUND.
REQ-017 SHALL have port Status, output, 2 bits: bit0 = master abort, bit1 = target stop; valid while Done=1.
REQ-018 SHALL have port Xfer_count, output, 4 bits: number of completed data phases in the current or last transaction.
REQ-019 SHALL have port Frame, output, 1 bit: PCI FRAME#, active-low.
REQ-020 SHALL have port Irdy, output, 1 bit: PCI IRDY#, active-low.
REQ-021 SHALL have ports Trdy, Devsel and Stop, each input, 1 bit: PCI target TRDY#, DEVSEL# and STOP#, all active-low.
REQ-022 SHALL have port Address, inout, 32 bits: PCI AD bus; high-impedance when not driven.
REQ-023 SHALL have port Cbe, output, 4 bits: PCI C/BE#; high-impedance when not driven.

Function
REQ-024 SHALL implement states IDLE, ADDR, DATA and TURNAROUND.
REQ-025 SHALL, in IDLE: Frame=1, Irdy=1, Address and Cbe Z; on Req=1, capture the request fields, clear Xfer_count and Status, and go to ADDR.
REQ-026 SHALL clamp Req_len: 0 is treated as 1; values above MAX_BURST are treated as MAX_BURST.
REQ-027 SHALL, in ADDR (exactly 1 cycle): Frame=0, Irdy=1, Address=captured address, Cbe=CMD_WRITE or CMD_READ; then go to DATA.
REQ-028 SHALL, in DATA: Irdy=0, Cbe=4'b0000; drive Address=Wr_data for a write; hold Address at Z for a read.
REQ-029 SHALL hold Frame=0 in DATA while more than one phase remains, and Frame=1 while the last phase is pending.
REQ-030 SHALL treat a data phase as complete on a rising edge with Irdy=0 and Trdy=0; on completion, increment Xfer_count, and for a read register Rd_data<=Address and Rd_valid<=1 for the next cycle.
REQ-031 SHALL go to TURNAROUND on completion of the last phase.
REQ-032 SHALL go to TURNAROUND with Status[1]=1 when an edge in DATA samples Stop=0; a phase completing on that same edge SHALL be counted.
REQ-033 SHALL count consecutive DATA edges with Devsel=1 (the count stops once Devsel=0 is sampled); on reaching DEVSEL_TIMEOUT, go to TURNAROUND with Status[0]=1 and no phase counted.
REQ-034 SHALL, in TURNAROUND (1 cycle): Frame=1, Irdy=1, Address and Cbe Z, Done=1, Wr_ack=0; then go to IDLE.
REQ-035 SHALL ignore Req while Busy=1.
REQ-036 SHALL give Stop priority over Devsel timeout when both occur on the same edge.

Reset
REQ-037 SHALL, while Rst=0, immediately force IDLE, Frame=1, Irdy=1, Address and Cbe Z, and Wr_ack, Rd_valid, Busy, Done, Status, Xfer_count and Rd_data all 0, including mid-transaction; no Done SHALL be issued for an aborted transaction.

Verification
REQ-038 SHALL verify: write of len 3 to 0x00001F40, target Trdy=0 every cycle -> 3 Wr_ack pulses, Frame=1 during the 3rd phase, Done with Status=00 and Xfer_count=3.
REQ-039 SHALL verify: read of len 2, target inserts one Trdy=1 wait state, returns 0x11111111 then 0x00001111 -> Rd_valid twice with those values, Xfer_count=2.
REQ-040 SHALL verify: write of len 8 to 0x00001F41, Devsel held 1 -> Done after 5 DATA edges with Status=01 and Xfer_count=0.
REQ-041 SHALL verify: write of len 8, Stop=0 with Trdy=0 on the 4th phase -> Status=10, Xfer_count=4, bus released in TURNAROUND.
REQ-042 SHALL verify: Rst=0 asserted in the middle of DATA -> outputs reach reset values without a clock edge; Req after release starts a clean transaction.
REQ-043 SHALL verify: Req_len=0 gives 1 phase; Req_len=15 gives 8 phases; Req pulsed while Busy=1 is ignored.
